// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// The master modport is the pipeline side; the slave modport is the predictor.
interface branch_predictor_if #(
    parameter int CNT_W = 32
);
    // Fetch-stage lookup
    logic [31:0]      PC_F;
    logic             Predict_Taken_F;
    logic [31:0]      Predict_Target_F;
    logic             Valid_F;

    // Execute-stage training
    logic             Update_En;
    logic             Jump_E;
    logic [31:0]      PC_E;
    logic [31:0]      PC_Target_E;
    logic             Branch_Taken_E;
    logic             Predict_Taken_E;

    // Maintenance and statistics
    logic             Invalidate_Req;
    logic             Busy;
    logic [CNT_W-1:0] Mispredict_Count;

    modport master (
        output PC_F,
        output Update_En,
        output Jump_E,
        output PC_E,
        output PC_Target_E,
        output Branch_Taken_E,
        output Predict_Taken_E,
        output Invalidate_Req,
        input  Predict_Taken_F,
        input  Predict_Target_F,
        input  Valid_F,
        input  Busy,
        input  Mispredict_Count
    );

    modport slave (
        input  PC_F,
        input  Update_En,
        input  Jump_E,
        input  PC_E,
        input  PC_Target_E,
        input  Branch_Taken_E,
        input  Predict_Taken_E,
        input  Invalidate_Req,
        output Predict_Taken_F,
        output Predict_Target_F,
        output Valid_F,
        output Busy,
        output Mispredict_Count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational on the fetch PC; training from execute is registered.
// A sweep FSM clears every valid bit one entry per cycle on request, and a
// free-running counter tallies direction mispredicts.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input logic               CLK,
    input logic               RST,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sweep_ptr;
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   mispredict_q;

    logic [IDX_W-1:0]   f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;
    logic               f_taken;

    logic [IDX_W-1:0]   e_idx;
    logic [TAG_W-1:0]   e_tag;
    logic               e_hit;
    logic               e_taken;
    logic               do_update;
    logic               entry_we;
    logic               ctr_we;
    logic [CTR_W-1:0]   ctr_next;

    // Fetch-side lookup: entries are hidden entirely while a sweep runs
    assign f_idx   = bp.PC_F[IDX_W+1:2];
    assign f_tag   = bp.PC_F[31:IDX_W+2];
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && (state == IDLE);
    assign f_taken = f_hit && ctr_q[f_idx][CTR_W-1];

    assign bp.Valid_F          = f_hit;
    assign bp.Predict_Taken_F  = f_taken;
    assign bp.Predict_Target_F = f_taken ? target_q[f_idx] : (bp.PC_F + 32'd4);
    assign bp.Busy             = (state == SWEEP);
    assign bp.Mispredict_Count = mispredict_q;

    // Execute-side address split; a jump is treated as an always-taken branch
    assign e_idx   = bp.PC_E[IDX_W+1:2];
    assign e_tag   = bp.PC_E[31:IDX_W+2];
    assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_taken = bp.Jump_E || bp.Branch_Taken_E;

    // Decide which parts of the indexed entry get rewritten by this resolution
    always_comb begin
        do_update = bp.Update_En && (state == IDLE);
        entry_we  = do_update && e_taken;
        ctr_we    = 1'b0;
        ctr_next  = ctr_q[e_idx];
        if (do_update) begin
            if (bp.Jump_E) begin
                ctr_we   = 1'b1;
                ctr_next = CTR_MAX;
            end else if (e_hit) begin
                ctr_we = 1'b1;
                if (bp.Branch_Taken_E) begin
                    if (ctr_q[e_idx] != CTR_MAX) begin
                        ctr_next = ctr_q[e_idx] + CTR_W'(1);
                    end
                end else begin
                    if (ctr_q[e_idx] != '0) begin
                        ctr_next = ctr_q[e_idx] - CTR_W'(1);
                    end
                end
            end else if (bp.Branch_Taken_E) begin
                ctr_we   = 1'b1;
                ctr_next = CTR_WEAK;
            end
        end
    end

    // Tag, target and counter payload; meaningless until the valid bit is set, so no reset
    always_ff @(posedge CLK) begin
        if (entry_we) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= bp.PC_Target_E;
        end
        if (ctr_we) begin
            ctr_q[e_idx] <= ctr_next;
        end
    end

    // Sweep FSM owning the valid bits: sweep clears one entry per cycle, otherwise training allocates
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            sweep_ptr <= '0;
            valid_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (entry_we) begin
                        valid_q[e_idx] <= 1'b1;
                    end
                    if (bp.Invalidate_Req) begin
                        state     <= SWEEP;
                        sweep_ptr <= '0;
                    end
                end
                SWEEP: begin
                    valid_q[sweep_ptr] <= 1'b0;
                    sweep_ptr          <= sweep_ptr + IDX_W'(1);
                    if (sweep_ptr == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Mispredict tally counts every resolution, including those dropped during a sweep
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mispredict_q <= '0;
        end else if (bp.Update_En && (bp.Predict_Taken_E != e_taken)) begin
            mispredict_q <= mispredict_q + CNT_W'(1);
        end
    end
endmodule
